tape_ram_writer: RTL and testbench
==================================

// Module: tape_ram_writer
// PURPOSE
//  Downstream stage of the tape/TAP parser. Turns its level-style write outputs (tape_wr/tape_addr/tape_dout)
//  into discrete byte writes and buffers them in a small FIFO. Injects each byte into the Lynx RAM port only
//  in cycles the CPU leaves free. Throttles the HPS download through ioctl_wait so no byte is lost.
//  Reports progress and a done pulse to the top level.
// PARAMETERS
//  DEPTH      8   FIFO entries (power of 2, >=4); each entry = {addr[15:0], data[7:0]}
//  WR_CYCLES  2   cycles ram_we is held high per byte (>=1)
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high reset
//  ioctl_download in   1   HPS download active
//  tape_wr        in   1   parser write enable (level; may stay high across consecutive bytes)
//  tape_addr      in   16  parser target address
//  tape_dout      in   8   parser data byte
//  ram_free       in   1   1 = CPU not using RAM this cycle; slot may be taken
//  ram_owner      out  1   1 = this block drives the RAM port (top-level mux select)
//  ram_addr       out  16  RAM address (valid while ram_owner)
//  ram_din        out  8   RAM write data (valid while ram_owner)
//  ram_we         out  1   RAM write strobe
//  ioctl_wait     out  1   back-pressure to HPS: stall download
//  overflow       out  1   sticky: a byte was dropped because the FIFO was full
//  bytes_written  out  16  bytes committed to RAM in the current download (wraps at 16 bits)
//  load_done      out  1   one-cycle pulse: download ended and all buffered bytes are committed
// BEHAVIOUR
//  Reset: FIFO flushed (count=0), FSM=IDLE, all outputs 0, edge/last-addr registers cleared.
//   Reset mid-write: ram_we=0 from the next cycle; pending bytes are discarded.
//  Capture: registers tape_wr_d and addr_d. A byte is new in a cycle where
//   tape_wr=1 AND (tape_wr_d=0 OR tape_addr!=addr_d).
//   The new {tape_addr,tape_dout} is enqueued at that clock edge. Repeated cycles with the same address are ignored.
//  FIFO full at capture: byte dropped, overflow<=1. overflow stays set until reset or ioctl_download rises.
//  Simultaneous enqueue and pop: both take effect; count is unchanged. Pointers wrap modulo DEPTH.
//  ioctl_wait: registered; equals (count >= DEPTH-2) evaluated on next-state count. Leaves 2 slots of
//   slack for bytes already in flight through the parser.
//  Write FSM:
//   IDLE  : ram_owner=0, ram_we=0. If count!=0 AND ram_free -> OWN.
//   OWN   : ram_owner=1. ram_addr/ram_din = FIFO head. ram_we=0 (1-cycle setup).
//           ram_free=1 -> WRITE. ram_free=0 -> IDLE with no pop (abort; retried later).
//   WRITE : ram_owner=1, ram_we=1 for WR_CYCLES cycles. ram_free is ignored (committed).
//           On the last cycle: pop head, bytes_written+=1, -> IDLE.
//   Per byte, minimum 2+WR_CYCLES cycles from IDLE back to IDLE. ram_addr/ram_din hold stable throughout OWN/WRITE.
//  Download framing:
//   ioctl_download rising edge: bytes_written<=0, overflow<=0, done_pending<=0.
//   ioctl_download falling edge: done_pending<=1.
//   done_pending AND count=0 AND FSM=IDLE: load_done=1 for exactly one cycle, then done_pending<=0.
//   Download rising again while done_pending is set: pending cleared, no pulse.
//   Capture stays active when ioctl_download=0 (the parser may still flush).
// TESTING
//  1 Reset: hold reset 3 cycles with tape_wr=1 -> all outputs 0, count 0, no ram_we.
//  2 Single byte: tape_wr 0->1 with addr=0x694D, data=0xA5, ram_free=1 ->
//    ram_owner rises 1 cycle after enqueue; ram_we high 2 cycles at 0x694D/0xA5; bytes_written=1.
//  3 Level write: tape_wr held 1; addr steps 0x694D,0x694D,0x694E,0x694F ->
//    exactly 3 RAM writes, in address order.
//  4 Contention: ram_free=0 for 20 cycles while 5 bytes arrive -> no ram_we; ioctl_wait=0.
//    Then 6th byte -> ioctl_wait=1 (count 6 >= 6).
//    Release ram_free -> all 6 written in order; ioctl_wait drops at count 5.
//  5 Abort: ram_free drops during OWN -> no ram_we, head kept; rewritten later exactly once.
//  6 Overflow/done: fill 8, send 9th -> overflow=1, 9th dropped.
//    Drain, drop ioctl_download -> load_done one pulse after the last pop; bytes_written=8.

Source files
------------

// File: rtl/tape_ram_writer.sv
// Tape parser to Lynx RAM writer: captures parser writes into a small FIFO
// and commits them into RAM cycles the CPU leaves free, throttling the HPS.
module tape_ram_writer #(
    parameter int DEPTH     = 8,
    parameter int WR_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        tape_wr,
    input  logic [15:0] tape_addr,
    input  logic [7:0]  tape_dout,
    input  logic        ram_free,
    output logic        ram_owner,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic        ioctl_wait,
    output logic        overflow,
    output logic [15:0] bytes_written,
    output logic        load_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [1:0]    state;
    logic [WW-1:0] wr_cnt;
    logic          tape_wr_d;
    logic [15:0]   addr_d;
    logic          dl_d;
    logic          done_pending;
    logic          is_new;
    logic          full;
    logic          push;
    logic          drop;
    logic          pop;
    logic          dl_rise;
    logic          dl_fall;
    logic [23:0]   head;

    // A repeated address while tape_wr stays high is the same byte, not a new one.
    assign is_new     = tape_wr && (!tape_wr_d || (tape_addr != addr_d));
    assign full       = (count == CW'(DEPTH));
    assign push       = is_new && !full;
    assign drop       = is_new && full;
    assign pop        = (state == S_WRITE) && (wr_cnt == WW'(WR_CYCLES - 1));
    assign count_next = count + CW'(push) - CW'(pop);
    assign dl_rise    = ioctl_download && !dl_d;
    assign dl_fall    = !ioctl_download && dl_d;
    assign head       = mem[rd_ptr];

    assign ram_owner  = (state != S_IDLE);
    assign ram_we     = (state == S_WRITE);
    assign ram_addr   = ram_owner ? head[23:8] : 16'h0000;
    assign ram_din    = ram_owner ? head[7:0]  : 8'h00;

    // Edge-detect registers for parser writes and the download flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            tape_wr_d <= 1'b0;
            addr_d    <= 16'h0000;
            dl_d      <= 1'b0;
        end else begin
            tape_wr_d <= tape_wr;
            addr_d    <= tape_addr;
            dl_d      <= ioctl_download;
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {tape_addr, tape_dout};
        end
    end

    // FIFO pointers, occupancy and the two-slot-early download throttle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ioctl_wait <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            ioctl_wait <= (count_next >= CW'(DEPTH - 2));
        end
    end

    // RAM slot FSM: claim, one setup cycle, then a committed write burst.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            wr_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    wr_cnt <= '0;
                    if ((count != '0) && ram_free) state <= S_OWN;
                end
                S_OWN: begin
                    wr_cnt <= '0;
                    state  <= ram_free ? S_WRITE : S_IDLE;
                end
                S_WRITE: begin
                    if (pop) begin
                        state  <= S_IDLE;
                        wr_cnt <= '0;
                    end else begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    wr_cnt <= '0;
                end
            endcase
        end
    end

    // Download framing: progress count, sticky overflow and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            bytes_written <= 16'h0000;
            overflow      <= 1'b0;
            done_pending  <= 1'b0;
            load_done     <= 1'b0;
        end else begin
            load_done <= 1'b0;
            if (dl_rise) begin
                bytes_written <= 16'h0000;
                overflow      <= 1'b0;
                done_pending  <= 1'b0;
            end else begin
                if (pop) bytes_written <= bytes_written + 16'h0001;
                if (dl_fall) begin
                    done_pending <= 1'b1;
                end else if (done_pending && (count == '0) && (state == S_IDLE)) begin
                    load_done    <= 1'b1;
                    done_pending <= 1'b0;
                end
            end
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tape_ram_writer.sv
// Scoreboard bench for tape_ram_writer: directed byte streams, expected RAM
// writes queued at issue time and checked by an independent monitor.
module tb_tape_ram_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        tape_wr;
    logic [15:0] tape_addr;
    logic [7:0]  tape_dout;
    logic        ram_free;
    logic        ram_owner;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ioctl_wait;
    logic        overflow;
    logic [15:0] bytes_written;
    logic        load_done;

    int passed = 0;
    int total  = 0;

    logic [23:0] exp_q[$];
    logic [23:0] cur = '0;
    int cyc = 0;
    int wr_seen = 0;
    int we_len = 0;
    int last_we_cyc = 0;
    int done_cnt = 0;
    int done_len = 0;
    int done_cyc = 0;
    logic we_prev = 1'b0;
    logic ld_prev = 1'b0;

    tape_ram_writer #(.DEPTH(8), .WR_CYCLES(2)) dut (
        .clk(clk),
        .reset(reset),
        .ioctl_download(ioctl_download),
        .tape_wr(tape_wr),
        .tape_addr(tape_addr),
        .tape_dout(tape_dout),
        .ram_free(ram_free),
        .ram_owner(ram_owner),
        .ram_addr(ram_addr),
        .ram_din(ram_din),
        .ram_we(ram_we),
        .ioctl_wait(ioctl_wait),
        .overflow(overflow),
        .bytes_written(bytes_written),
        .load_done(load_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] a, input logic [7:0] d, input bit expect_it);
        tape_addr = a;
        tape_dout = d;
        tape_wr   = 1'b1;
        if (expect_it) exp_q.push_back({a, d});
        step();
        tape_wr = 1'b0;
        step();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        sample();
        while ((exp_q.size() != 0 || ram_owner) && n < budget) begin
            sample();
            n++;
        end
        if (n >= budget) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: every RAM write burst must match the scoreboard head.
    always @(negedge clk) begin
        cyc++;
        if (load_done) begin
            done_len++;
            done_cyc = cyc;
            if (!ld_prev) done_cnt++;
        end
        ld_prev = load_done;
        if (ram_we) begin
            last_we_cyc = cyc;
            if (!we_prev) begin
                wr_seen++;
                we_len = 0;
                if (exp_q.size() == 0) chk("spurious_we", 32'd1, 32'd0);
                else cur = exp_q.pop_front();
            end
            we_len++;
            chk("we_addr_data", {8'h00, ram_addr, ram_din}, {8'h00, cur});
            chk("we_owner", {31'd0, ram_owner}, 32'd1);
        end else if (we_prev) begin
            chk("we_len", we_len, 32'd2);
        end else if (ram_owner && exp_q.size() != 0) begin
            chk("own_head", {8'h00, ram_addr, ram_din}, {8'h00, exp_q[0]});
        end
        we_prev = ram_we;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        reset = 1'b1;
        ioctl_download = 1'b0;
        tape_wr = 1'b1;
        tape_addr = 16'h1234;
        tape_dout = 8'h99;
        ram_free = 1'b1;

        repeat (3) step();
        sample();
        chk("reset_outs", {ram_owner, ram_we, ioctl_wait, overflow, load_done, bytes_written},
            32'd0);
        chk("reset_ram", {8'h00, ram_addr, ram_din}, 32'd0);
        chk("reset_nowe", wr_seen, 32'd0);
        reset = 1'b0;
        tape_wr = 1'b0;
        ioctl_download = 1'b1;
        repeat (2) step();

        tape_addr = 16'h694D;
        tape_dout = 8'hA5;
        tape_wr = 1'b1;
        exp_q.push_back({16'h694D, 8'hA5});
        step();
        tape_wr = 1'b0;
        sample();
        chk("single_owner_lat0", {31'd0, ram_owner}, 32'd0);
        sample();
        chk("single_owner_lat1", {30'd0, ram_owner, ram_we}, 32'd2);
        wait_idle(40);
        chk("single_bw", {16'h0, bytes_written}, 32'd1);

        tape_wr = 1'b1;
        tape_addr = 16'h694D; tape_dout = 8'h11;
        exp_q.push_back({16'h694D, 8'h11});
        step();
        tape_dout = 8'h22;
        step();
        tape_addr = 16'h694E; tape_dout = 8'h33;
        exp_q.push_back({16'h694E, 8'h33});
        step();
        tape_addr = 16'h694F; tape_dout = 8'h44;
        exp_q.push_back({16'h694F, 8'h44});
        step();
        tape_wr = 1'b0;
        wait_idle(60);
        chk("level_writes", wr_seen, 32'd4);
        chk("level_bw", {16'h0, bytes_written}, 32'd4);

        ram_free = 1'b0;
        base = wr_seen;
        for (int i = 0; i < 5; i++) send(16'h1000 + 16'(i), 8'hC0 + 8'(i), 1'b1);
        repeat (10) step();
        sample();
        chk("cont_wait5", {31'd0, ioctl_wait}, 32'd0);
        chk("cont_nowe", wr_seen - base, 32'd0);
        chk("cont_noown", {31'd0, ram_owner}, 32'd0);
        tape_addr = 16'h1005; tape_dout = 8'hC5; tape_wr = 1'b1;
        exp_q.push_back({16'h1005, 8'hC5});
        step();
        tape_wr = 1'b0;
        sample();
        chk("cont_wait6", {31'd0, ioctl_wait}, 32'd1);
        ram_free = 1'b1;
        sample();
        chk("cont_wait_hold", {31'd0, ioctl_wait}, 32'd1);
        begin
            int n;
            n = 0;
            while (bytes_written != 16'd5 && n < 40) begin
                sample();
                n++;
            end
            chk("cont_first_pop", {16'h0, bytes_written}, 32'd5);
            chk("cont_wait_drop", {31'd0, ioctl_wait}, 32'd0);
        end
        wait_idle(80);
        chk("cont_bw", {16'h0, bytes_written}, 32'd10);

        ram_free = 1'b0;
        base = wr_seen;
        send(16'h2000, 8'h5A, 1'b1);
        ram_free = 1'b1;
        step();
        ram_free = 1'b0;
        sample();
        chk("abort_own", {30'd0, ram_owner, ram_we}, 32'd2);
        repeat (6) step();
        sample();
        chk("abort_nowe", wr_seen - base, 32'd0);
        chk("abort_released", {31'd0, ram_owner}, 32'd0);
        chk("abort_bw", {16'h0, bytes_written}, 32'd10);
        ram_free = 1'b1;
        wait_idle(40);
        chk("abort_once", wr_seen - base, 32'd1);
        chk("abort_bw2", {16'h0, bytes_written}, 32'd11);

        ioctl_download = 1'b0;
        step();
        ioctl_download = 1'b1;
        repeat (4) step();
        sample();
        chk("restart_bw", {16'h0, bytes_written}, 32'd0);
        chk("restart_nodone", done_cnt, 32'd0);
        ram_free = 1'b0;
        for (int i = 0; i < 8; i++) send(16'h3000 + 16'(i), 8'h70 + 8'(i), 1'b1);
        sample();
        chk("full_wait", {31'd0, ioctl_wait}, 32'd1);
        chk("full_noovf", {31'd0, overflow}, 32'd0);
        send(16'h3008, 8'h78, 1'b0);
        sample();
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        ioctl_download = 1'b0;
        repeat (5) step();
        sample();
        chk("done_held", done_cnt, 32'd0);
        ram_free = 1'b1;
        wait_idle(120);
        repeat (5) step();
        sample();
        chk("done_pulses", done_cnt, 32'd1);
        chk("done_width", done_len, 32'd1);
        chk("done_timing", done_cyc - last_we_cyc, 32'd2);
        chk("ovf_bw", {16'h0, bytes_written}, 32'd8);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        ioctl_download = 1'b1;
        repeat (2) step();
        sample();
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
        chk("rise_bw_clear", {16'h0, bytes_written}, 32'd0);
        chk("queue_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
